// File: rtl/spectrum_pkg.sv
// spectrum_pkg: definitions shared by the spectrum capture block, the
// modulus stage and the display reader.
//   state_t     - capture controller states
//   SPEC_N_FFT  - default FFT length of the system
//   SPEC_BIN_W  - width of a half-spectrum bin index for SPEC_N_FFT
package spectrum_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int SPEC_N_FFT = 256;
    // Only the lower half of the spectrum is kept, so bins need log2(N/2) bits.
    localparam int SPEC_BIN_W = $clog2(SPEC_N_FFT / 2);

endpackage

// File: rtl/spectrum_ram.sv
// spectrum_ram: simple dual-port RAM, one write port and one registered
// read port, written so synthesis maps it onto block RAM.
//   clk      - clock
//   rst_n    - asynchronous active-low reset (read data register only)
//   we       - write enable
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address
//   rd_data  - read data, one cycle after rd_addr; a read of the address
//              being written in the same cycle returns the old contents
module spectrum_ram #(
    parameter int DEPTH  = 128,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write: the register samples the array before this edge's write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/spectrum_capture.sv
// spectrum_capture: sink for the FFT magnitude stream. On arm it aligns to
// the next frame boundary, stores bins 0..N_FFT/2-1 of one complete frame,
// tracks the peak bin (excluding the lowest DC_BINS bins) and raises done.
//   clk, rst_n          - clock, asynchronous active-low reset
//   arm                 - one-cycle start/restart request
//   mod_data/valid/eop  - magnitude stream (eop marks last sample of a frame)
//   rd_addr, rd_data    - synchronous buffer read port, 1-cycle latency
//   busy                - searching for a boundary or capturing
//   done                - frame stored, peak outputs final
//   peak_val, peak_bin  - largest magnitude and its bin
//   frame_err           - sticky framing error, cleared by arm
module spectrum_capture
    import spectrum_pkg::*;
#(
    parameter int N_FFT   = SPEC_N_FFT,
    parameter int DATA_W  = 16,
    parameter int BIN_W   = SPEC_BIN_W,
    parameter int DC_BINS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic [DATA_W-1:0] mod_data,
    input  logic              mod_valid,
    input  logic              mod_eop,
    input  logic [BIN_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] peak_val,
    output logic [BIN_W-1:0]  peak_bin,
    output logic              frame_err
);

    // The counter spans a full frame; one extra bit beyond the stored half.
    localparam logic [BIN_W:0] LAST_BIN = (BIN_W+1)'(N_FFT - 1);
    localparam logic [BIN_W:0] HALF_BIN = (BIN_W+1)'(N_FFT / 2);
    localparam logic [BIN_W:0] DC_LIM   = (BIN_W+1)'(DC_BINS);

    state_t            state_reg;
    logic [BIN_W:0]    bin_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [DATA_W-1:0] peak_val_reg;
    logic [BIN_W-1:0]  peak_bin_reg;
    logic              frame_err_reg;

    logic in_half;
    logic peak_hit;
    logic buf_we;

    assign in_half  = (bin_reg < HALF_BIN);
    // Strict compare keeps the lowest bin on ties.
    assign peak_hit = in_half && (bin_reg >= DC_LIM) && (mod_data > peak_val_reg);
    // Suppressed under arm; the stored frame is being abandoned anyway.
    assign buf_we   = (state_reg == CAPTURE) && mod_valid && in_half && !arm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            bin_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            peak_val_reg  <= '0;
            peak_bin_reg  <= '0;
            frame_err_reg <= 1'b0;
        end else if (arm) begin
            // arm overrides everything, including a coincident eop.
            state_reg     <= SYNC;
            busy_reg      <= 1'b1;
            done_reg      <= 1'b0;
            peak_val_reg  <= '0;
            peak_bin_reg  <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: ;
                SYNC: begin
                    // A valid eop is the only frame boundary marker in the stream.
                    if (mod_valid && mod_eop) begin
                        state_reg    <= CAPTURE;
                        bin_reg      <= '0;
                        peak_val_reg <= '0;
                        peak_bin_reg <= '0;
                    end
                end
                CAPTURE: begin
                    if (mod_valid) begin
                        if (mod_eop) begin
                            if (bin_reg == LAST_BIN) begin
                                state_reg <= DONE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end else begin
                                // Short frame: its eop still marks a boundary,
                                // so start over on the next sample.
                                frame_err_reg <= 1'b1;
                                bin_reg       <= '0;
                                peak_val_reg  <= '0;
                                peak_bin_reg  <= '0;
                            end
                        end else if (bin_reg == LAST_BIN) begin
                            // Long frame: alignment lost, hunt for the next eop.
                            frame_err_reg <= 1'b1;
                            state_reg     <= SYNC;
                        end else begin
                            if (peak_hit) begin
                                peak_val_reg <= mod_data;
                                peak_bin_reg <= bin_reg[BIN_W-1:0];
                            end
                            bin_reg <= bin_reg + 1'b1;
                        end
                    end
                end
                DONE: ;
                default: state_reg <= IDLE;
            endcase
        end
    end

    spectrum_ram #(
        .DEPTH  (N_FFT / 2),
        .DATA_W (DATA_W),
        .ADDR_W (BIN_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (buf_we),
        .wr_addr (bin_reg[BIN_W-1:0]),
        .wr_data (mod_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign peak_val  = peak_val_reg;
    assign peak_bin  = peak_bin_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_spectrum_capture.sv
module tb_spectrum_capture;

    localparam int N    = 256;
    localparam int HALF = 128;
    localparam int DC   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm;
    logic [15:0] mod_data;
    logic        mod_valid;
    logic        mod_eop;
    logic [6:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic [15:0] peak_val;
    logic [6:0]  peak_bin;
    logic        frame_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] fr [N];

    spectrum_capture #(
        .N_FFT   (N),
        .DATA_W  (16),
        .BIN_W   (7),
        .DC_BINS (DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .mod_data  (mod_data),
        .mod_valid (mod_valid),
        .mod_eop   (mod_eop),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .peak_val  (peak_val),
        .peak_bin  (peak_bin),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-18s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one cycle at a negedge; returns on the next negedge.
    task automatic cyc(input bit v, input logic [15:0] d, input bit e, input bit a);
        mod_valid = v;
        mod_data  = d;
        mod_eop   = e;
        arm       = a;
        @(negedge clk);
        mod_valid = 1'b0;
        mod_eop   = 1'b0;
        arm       = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit eop_last, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 0) cyc(1'b0, 16'h0, 1'b0, 1'b0);
            end
            cyc(1'b1, fr[i], eop_last && (i == n - 1), 1'b0);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [6:0] a, input logic [15:0] exp);
        rd_addr = a;
        @(negedge clk);
        chk(tag, rd_data, exp);
    endtask

    // Arm, then feed one eop so the next sample is bin 0.
    task automatic arm_and_sync();
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        cyc(1'b1, 16'hBEEF, 1'b1, 1'b0);
    endtask

    initial begin
        logic [15:0] exp_pv;
        logic [6:0]  exp_pb;

        rst_n = 1'b0; arm = 1'b0; mod_data = '0; mod_valid = 1'b0; mod_eop = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_peak_val", peak_val, 0);
        chk("rst_peak_bin", peak_bin, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_rd_data", rd_data, 0);

        // 1: ramp with one large bin
        for (int k = 0; k < N; k++) fr[k] = 16'(k);
        fr[40] = 16'hFFFF;
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk("t1_busy_armed", busy, 1);
        cyc(1'b1, 16'h0, 1'b1, 1'b0);
        send_frame(N - 1, 1'b0, 1'b0);
        chk("t1_done_pre", done, 0);
        chk("t1_busy_pre", busy, 1);
        cyc(1'b1, fr[N-1], 1'b1, 1'b0);
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_peak_val", peak_val, 16'hFFFF);
        chk("t1_peak_bin", peak_bin, 40);
        rd_chk("t1_rd5", 7'd5, 16'd5);
        rd_chk("t1_rd40", 7'd40, 16'hFFFF);
        rd_chk("t1_rd127", 7'd127, 16'd127);
        // DONE ignores further traffic
        for (int k = 0; k < N; k++) fr[k] = 16'h7777;
        send_frame(N, 1'b1, 1'b0);
        chk("t1_hold_done", done, 1);
        chk("t1_hold_peak", peak_val, 16'hFFFF);
        rd_chk("t1_hold_rd5", 7'd5, 16'd5);

        // 2: arm mid-frame, partial frame discarded
        for (int k = 0; k < 50; k++) cyc(1'b1, 16'hAAAA, 1'b0, 1'b0);
        cyc(1'b1, 16'hAAAA, 1'b0, 1'b1);
        chk("t2_done_cleared", done, 0);
        chk("t2_busy", busy, 1);
        chk("t2_peak_cleared", peak_val, 0);
        for (int k = 51; k < N; k++) cyc(1'b1, 16'hAAAA, k == N - 1, 1'b0);
        chk("t2_not_done", done, 0);
        for (int k = 0; k < N; k++) fr[k] = 16'(1000 + (k % HALF));
        send_frame(N, 1'b1, 1'b0);
        chk("t2_done", done, 1);
        chk("t2_peak_val", peak_val, 16'd1127);
        chk("t2_peak_bin", peak_bin, 127);
        rd_chk("t2_rd0", 7'd0, 16'd1000);
        rd_chk("t2_rd64", 7'd64, 16'd1064);

        // 3: DC bins excluded, tie keeps lowest bin
        for (int k = 0; k < N; k++) fr[k] = 16'h0;
        fr[0] = 16'h7000; fr[1] = 16'h6000; fr[10] = 16'h0100; fr[20] = 16'h0100;
        arm_and_sync();
        send_frame(N, 1'b1, 1'b0);
        chk("t3_done", done, 1);
        chk("t3_peak_val", peak_val, 16'h0100);
        chk("t3_peak_bin", peak_bin, 10);
        rd_chk("t3_rd0", 7'd0, 16'h7000);

        // 4: short frame then good frame
        for (int k = 0; k < N; k++) fr[k] = 16'h5000;
        arm_and_sync();
        send_frame(101, 1'b1, 1'b0);
        chk("t4_frame_err", frame_err, 1);
        chk("t4_busy", busy, 1);
        chk("t4_not_done", done, 0);
        for (int k = 0; k < N; k++) fr[k] = 16'(k);
        fr[77] = 16'h1234;
        send_frame(N, 1'b1, 1'b0);
        chk("t4_done", done, 1);
        chk("t4_err_sticky", frame_err, 1);
        chk("t4_peak_val", peak_val, 16'h1234);
        chk("t4_peak_bin", peak_bin, 77);
        rd_chk("t4_rd3", 7'd3, 16'd3);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk("t4_err_cleared", frame_err, 0);
        chk("t4_done_cleared", done, 0);

        // 5: long frame (no eop at bin 255)
        cyc(1'b1, 16'h0, 1'b1, 1'b0);
        for (int k = 0; k < N; k++) fr[k] = 16'(2 * k);
        send_frame(N - 1, 1'b0, 1'b0);
        chk("t5_err_pre", frame_err, 0);
        cyc(1'b1, fr[N-1], 1'b0, 1'b0);
        chk("t5_frame_err", frame_err, 1);
        chk("t5_busy", busy, 1);
        chk("t5_not_done", done, 0);
        cyc(1'b1, 16'hFFFF, 1'b1, 1'b0);
        send_frame(N, 1'b1, 1'b0);
        chk("t5_done", done, 1);
        chk("t5_peak_val", peak_val, 16'd254);
        chk("t5_peak_bin", peak_bin, 127);

        // 6: random data with gaps against a reference peak search
        for (int k = 0; k < N; k++) fr[k] = 16'($urandom_range(0, 16'hFFFF));
        exp_pv = '0; exp_pb = '0;
        for (int k = DC; k < HALF; k++) begin
            if (fr[k] > exp_pv) begin exp_pv = fr[k]; exp_pb = 7'(k); end
        end
        arm_and_sync();
        send_frame(N, 1'b1, 1'b1);
        chk("t6_done", done, 1);
        chk("t6_peak_val", peak_val, exp_pv);
        chk("t6_peak_bin", peak_bin, exp_pb);
        for (int a = 0; a < HALF; a += 21) rd_chk("t6_rd", 7'(a), fr[a]);
        rd_chk("t6_rd127", 7'd127, fr[127]);
        // arm coincident with eop mid-capture: must land in SYNC, not restart capture
        arm_and_sync();
        for (int k = 0; k < 10; k++) cyc(1'b1, 16'h0, 1'b0, 1'b0);
        cyc(1'b1, 16'h0, 1'b1, 1'b1);
        chk("t6_arm_err", frame_err, 0);
        chk("t6_arm_busy", busy, 1);
        send_frame(N, 1'b1, 1'b0);
        chk("t6_sync_not_done", done, 0);
        send_frame(N, 1'b1, 1'b0);
        chk("t6_sync_done", done, 1);

        // 7: asynchronous reset mid-capture returns to IDLE
        arm_and_sync();
        for (int k = 0; k < 5; k++) cyc(1'b1, 16'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("t7_busy", busy, 0);
        send_frame(N, 1'b1, 1'b0);
        send_frame(N, 1'b1, 1'b0);
        chk("t7_idle_done", done, 0);
        chk("t7_idle_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
